// File: rtl/mwb_pkg.sv
// Shared definitions for the memory/write-back stage.
//   - RV32 opcode constants used by the decoder
//   - funct3 access-size codes for loads and stores
//   - FSM state encoding
//   - helper that classifies opcodes which write the ALU result back
package mwb_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } mwb_state_t;

  // Opcodes whose result is the ALU output written straight to rd.
  function automatic logic writes_alu(input logic [6:0] opc);
    logic r;
    r = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mwb_load_align.sv
// Load data alignment and extension.
// Ports:
//   rdata  in  32  raw word returned by data memory
//   off    in  2   byte offset of the access (addr[1:0])
//   funct3 in  3   load size/sign code
//   value  out 32  value to write to the register file
// Bytes select lane off, halves select lane off[1]; LB/LH sign-extend,
// LBU/LHU zero-extend, LW and any unrecognised code return the full word.
module mwb_load_align
  import mwb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = rdata;
    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'b0, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'b0, half_sel};
      F3_W:    value = rdata;
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mwb_stage.sv
// Memory/write-back stage of the three-stage pipeline.
// Consumes the EX/MWB register, performs loads/stores over a req/ready
// data-memory interface and drives the register-file write port.
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   EX_MWB_ALU_Out         ALU result / effective address
//   EX_MWB_IR              instruction word
//   EX_MWB_stall           1 = bubble, instruction ignored
//   EX_MWB_rs2             store data
//   mem_req/we/addr/wdata/be  data-memory request (registered)
//   mem_rdata, mem_ready   data-memory response
//   rf_we/waddr/wdata      register-file write port (one-cycle pulse)
//   mwb_busy               freeze request to upstream while an access is open
//   misalign_err           one-cycle pulse, misaligned access dropped
//   timeout_err            one-cycle pulse, access aborted after MEM_TIMEOUT
//
// Memory handshake: mem_req rises with all mem_* fields valid and they stay
// stable until the first rising edge at which mem_ready=1 is sampled; that
// edge completes the access and mem_req falls. mem_ready is only looked at
// while a request is outstanding. One access is open at a time.
module mwb_stage
  import mwb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] EX_MWB_ALU_Out,
  input  logic [31:0]     EX_MWB_IR,
  input  logic            EX_MWB_stall,
  input  logic [XLEN-1:0] EX_MWB_rs2,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            mwb_busy,
  output logic            misalign_err,
  output logic            timeout_err
);

  // Last count value before abort: the abort happens on the edge that
  // would take the counter to MEM_TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  off;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Upper instruction bits carry nothing this stage needs.
  logic unused_ir;
  assign unused_ir = ^EX_MWB_IR[31:15];

  assign opcode   = EX_MWB_IR[6:0];
  assign funct3   = EX_MWB_IR[14:12];
  assign rd       = EX_MWB_IR[11:7];
  assign off      = EX_MWB_ALU_Out[1:0];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load | is_store;

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Lane generation. funct3[1:0] gives the size for both loads and stores
  // (BU/HU share it with B/H), so byte enables describe the loaded bytes too.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = EX_MWB_rs2;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {24'b0, EX_MWB_rs2[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = off[1] ? {EX_MWB_rs2[15:0], 16'b0}
                          : {16'b0, EX_MWB_rs2[15:0]};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = EX_MWB_rs2;
      end
    endcase
  end

  // ------------------------------------------------------ pending access
  logic [2:0]  pend_f3_q, pend_f3_d;
  logic [1:0]  pend_off_q, pend_off_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        pend_load_q, pend_load_d;
  logic [31:0] load_value;

  mwb_load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (pend_off_q),
    .funct3 (pend_f3_q),
    .value  (load_value)
  );

  // ------------------------------------------------------------------ FSM
  mwb_state_t       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic            mem_req_d;
  logic            mem_we_d;
  logic [31:0]     mem_addr_d;
  logic [31:0]     mem_wdata_d;
  logic [3:0]      mem_be_d;
  logic            rf_we_d;
  logic [4:0]      rf_waddr_d;
  logic [31:0]     rf_wdata_d;
  logic            mwb_busy_d;
  logic            misalign_err_d;
  logic            timeout_err_d;

  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    mem_be_d       = mem_be;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr;
    rf_wdata_d     = rf_wdata;
    mwb_busy_d     = mwb_busy;
    misalign_err_d = 1'b0;
    timeout_err_d  = 1'b0;
    pend_f3_d      = pend_f3_q;
    pend_off_d     = pend_off_q;
    pend_rd_d      = pend_rd_q;
    pend_load_d    = pend_load_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (!EX_MWB_stall) begin
          if (is_mem) begin
            if (misaligned) begin
              misalign_err_d = 1'b1;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = is_store;
              mem_addr_d  = {EX_MWB_ALU_Out[31:2], 2'b00};
              mem_be_d    = st_be;
              mem_wdata_d = is_store ? st_wdata : 32'h0;
              mwb_busy_d  = 1'b1;
              pend_f3_d   = funct3;
              pend_off_d  = off;
              pend_rd_d   = rd;
              pend_load_d = is_load;
              state_d     = ST_MEM_WAIT;
            end
          end else if (writes_alu(opcode) && (rd != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = EX_MWB_ALU_Out;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          mwb_busy_d = 1'b0;
          tmo_d      = '0;
          state_d    = ST_IDLE;
          if (pend_load_q && (pend_rd_q != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pend_rd_q;
            rf_wdata_d = load_value;
          end
        end else if (tmo_q == TMO_LAST) begin
          mem_req_d     = 1'b0;
          mwb_busy_d    = 1'b0;
          timeout_err_d = 1'b1;
          tmo_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        mwb_busy_d = 1'b0;
        tmo_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= 4'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= 5'd0;
      rf_wdata     <= '0;
      mwb_busy     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      pend_f3_q    <= 3'b0;
      pend_off_q   <= 2'b0;
      pend_rd_q    <= 5'd0;
      pend_load_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_be       <= mem_be_d;
      rf_we        <= rf_we_d;
      rf_waddr     <= rf_waddr_d;
      rf_wdata     <= rf_wdata_d;
      mwb_busy     <= mwb_busy_d;
      misalign_err <= misalign_err_d;
      timeout_err  <= timeout_err_d;
      pend_f3_q    <= pend_f3_d;
      pend_off_q   <= pend_off_d;
      pend_rd_q    <= pend_rd_d;
      pend_load_q  <= pend_load_d;
    end
  end

endmodule
